bsc_axiu_stream_to_hs_fifo: RTL

Parametrised AXI-Stream to ap_hs handshake adapter with an internal first-word-fall-through FIFO of configurable width and depth. It also carries TLAST through to the HLS side and supports a synchronous flush. It sits between the accelerator's AXI-Stream ingress (from the command/data interconnect) and an HLS accelerator's `ap_hs` input port. The FIFO decouples burst arrivals from accelerator ack timing and breaks the combinational ack-to-tready path.

---
 rtl/bsc_axiu_pkg.sv | 14 +
 rtl/bsc_axiu_sync_fifo.sv | 76 +++++++
 rtl/bsc_axiu_stream_to_hs_fifo.sv | 53 +++++
 3 files changed

// File: rtl/bsc_axiu_pkg.sv
// Shared sizing helpers for the AXI-Stream / ap_hs adapter family.
package bsc_axiu_pkg;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Each stored entry carries tlast alongside the payload.
  function automatic int unsigned entry_width(input int unsigned data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/bsc_axiu_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; shared by both adapter directions.
module bsc_axiu_sync_fifo
  import bsc_axiu_pkg::*;
#(
  parameter int unsigned EntryW = 65,
  parameter int unsigned Depth  = 4,
  localparam int unsigned CntW  = cnt_width(Depth)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              flush,
  input  logic              push,
  input  logic [EntryW-1:0] push_data,
  input  logic              pop,
  output logic [EntryW-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CntW-1:0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("bsc_axiu_sync_fifo: Depth must be a power of two and at least 2");
  end

  logic [EntryW-1:0] mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Guard locally so a careless caller can never overflow or underflow.
  assign do_push = push && !full && !flush && aresetn;
  assign do_pop  = pop && !empty && !flush && aresetn;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) count_d = count_q + CntW'(1);
      if (do_pop && !do_push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/bsc_axiu_stream_to_hs_fifo.sv
// AXI-Stream ingress to HLS ap_hs input, decoupled by a FWFT FIFO carrying tlast.
module bsc_axiu_stream_to_hs_fifo
  import bsc_axiu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned CNT_W     = cnt_width(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] inStream_tdata,
  input  logic                  inStream_tlast,
  input  logic                  inStream_tvalid,
  output logic                  inStream_tready,
  output logic [DATA_WIDTH-1:0] out_hs,
  output logic                  out_hs_last,
  output logic                  out_hs_ap_vld,
  input  logic                  out_hs_ap_ack,
  output logic [CNT_W-1:0]      occupancy
);

  localparam int unsigned EntryW = entry_width(DATA_WIDTH);

  logic              full, empty, push, pop;
  logic [EntryW-1:0] head_data;

  // tready comes from registered state only, so ack never reaches it combinationally.
  assign inStream_tready = aresetn && !flush && !full;
  assign out_hs_ap_vld   = !flush && !empty;

  assign push = inStream_tvalid && inStream_tready;
  assign pop  = out_hs_ap_vld && out_hs_ap_ack;

  assign {out_hs_last, out_hs} = head_data;

  bsc_axiu_sync_fifo #(
    .EntryW (EntryW),
    .Depth  (DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .flush     (flush),
    .push      (push),
    .push_data ({inStream_tlast, inStream_tdata}),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (occupancy)
  );

endmodule
